mem_access: RTL

//  Load/store unit ahead of write-back. Drives data-memory requests. Lane-aligns and sign-extends load data

---
 rtl/mem_access.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: load/store unit driving data-memory requests, lane-aligning loads and
// producing byte strobes and lane-replicated data for stores, with a request timeout.
module mem_access #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        done,
   output logic [31:0] read_data,
   output logic [31:0] wb_mask,
   output logic        err,
   output logic [1:0]  err_code
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  f3;
   logic [1:0]  lane;
   logic        ld;
   logic        is_ld, is_st, bad_f3, misal;
   logic [3:0]  wstrb;
   logic [31:0] wdata, sh, ld_data, ld_mask;
   always_comb begin
      is_ld   = opcode == 7'b0000011;
      is_st   = opcode == 7'b0100011;
      bad_f3  = is_ld ? (funct3 == 3'b011 || funct3[2:1] == 2'b11) : is_st && funct3 > 3'b010;
      misal   = (is_ld || is_st) && (funct3[1:0] == 2'b01 ? addr[0] :
                funct3[1:0] == 2'b10 ? addr[1:0] != 2'b00 : 1'b0);
      wstrb   = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata   = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
      sh      = dmem_rdata >> {lane, 3'b000};
      ld_data = f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                f3 == 3'b100 ? {24'h0, sh[7:0]} :
                f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                f3 == 3'b101 ? {16'h0, sh[15:0]} : dmem_rdata;
      ld_mask = f3 == 3'b100 ? 32'h0000_00FF : f3 == 3'b101 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         f3         <= '0;
         lane       <= '0;
         ld         <= 1'b0;
         in_ready   <= 1'b1;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wstrb <= '0;
         done       <= 1'b0;
         read_data  <= '0;
         wb_mask    <= '0;
         err        <= 1'b0;
         err_code   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (in_valid) begin
                  in_ready   <= 1'b0;
                  f3         <= funct3;
                  lane       <= addr[1:0];
                  ld         <= is_ld;
                  cnt        <= '0;
                  err        <= 1'b0;
                  err_code   <= 2'd0;
                  read_data  <= '0;
                  wb_mask    <= '0;
                  dmem_addr  <= {addr[31:2], 2'b00};
                  dmem_we    <= is_st;
                  dmem_wstrb <= is_st ? wstrb : 4'b0000;
                  dmem_wdata <= is_st ? wdata : 32'h0;
                  if (bad_f3 || misal) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= bad_f3 ? 2'd3 : 2'd1;
                  end else if (!is_ld && !is_st) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= REQ;
                     dmem_req <= 1'b1;
                  end
               end
            end
            REQ: begin
               // an ack on the final allowed cycle takes priority over the timeout
               if (dmem_ack) begin
                  state     <= DONE;
                  dmem_req  <= 1'b0;
                  done      <= 1'b1;
                  read_data <= ld ? ld_data : 32'h0;
                  wb_mask   <= ld ? ld_mask : 32'h0;
               end else if (TIMEOUT != 8'd0 && cnt == TIMEOUT - 8'd1) begin
                  state    <= DONE;
                  dmem_req <= 1'b0;
                  done     <= 1'b1;
                  err      <= 1'b1;
                  err_code <= 2'd2;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               state    <= IDLE;
               done     <= 1'b0;
               in_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
